regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
- Write-back scheduler for the 15-entry Y86-64 register file read by the decode stage.
- The register file has a single physical write port. Each instruction can produce two results: valE to dstE and valM to dstM (for example popq writes rsp and rA).
- This block accepts one write-back request per instruction, serialises it into at most two write-port cycles, and shares the port with a low-priority debug/preload requester.

Parameters:
- NREG, 15, number of architectural registers; valid addresses are 0..NREG-1.
- DW, 64, data width.
- AW, 4, register address width; address 4'hF (RNONE) means "no write".

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  write-back request from the execute/memory side
- wb_ready  out  1  scheduler can accept a wb request this cycle
- wb_dstE  in  AW  destination for valE; RNONE = none
- wb_valE  in  DW  ALU result
- wb_dstM  in  AW  destination for valM; RNONE = none
- wb_valM  in  DW  memory result
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug request accepted this cycle
- dbg_addr  in  AW  debug write address
- dbg_data  in  DW  debug write data
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- wb_done  out  1  one-cycle pulse; the accepted instruction's write-back is complete
- busy  out  1  state != IDLE
- addr_err  out  1  sticky: a write to an address >= NREG and != RNONE was suppressed

Behaviour:
- FSM states:
  - IDLE
  - WR_E
  - WR_M
  - WR_D (debug write)
  - NOP (request with no destinations)
- Outputs are Moore, decoded from registered state and latched fields. There is no combinational path from wb_*/dbg_* inputs to rf_*.
- Reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, busy=0, addr_err=0. All latched fields are cleared.
- wb_ready = (state==IDLE). dbg_ready = (state==IDLE) && !wb_valid && dbg_valid.
  - A write-back request always wins over debug.
  - Debug is served only in cycles where no wb request is pending.
- Accepting a wb request (wb_valid && wb_ready at edge N) latches dstE, valE, dstM, valM. The next state is:
  - WR_E if dstE!=RNONE;
  - else WR_M if dstM!=RNONE;
  - else NOP.
- WR_E (cycle N+1): rf_we=1, rf_waddr=dstE, rf_wdata=valE. Next state is WR_M if dstM!=RNONE, else IDLE with wb_done=1 in this cycle.
- WR_M: rf_we=1, rf_waddr=dstM, rf_wdata=valM, wb_done=1. Next state is IDLE.
- NOP: rf_we=0, wb_done=1. Next state is IDLE.
- Latency and throughput:
  - A single-destination instruction takes 1 write cycle.
  - A dual-destination instruction takes 2 write cycles.
  - A new request is accepted no earlier than the cycle after wb_done, so throughput is at most one instruction every 2 cycles.
- Same destination (dstE==dstM, e.g. popq %rsp): E is written first, then M. The final register value is valM, as Y86 requires.
- Accepting a debug request latches addr and data and moves to WR_D: rf_we=1 for one cycle, wb_done=0. Next state is IDLE.
- Address check: in WR_E, WR_M or WR_D, if the address is >= NREG, then:
  - rf_we is forced to 0;
  - addr_err sets and stays set until reset;
  - sequencing and wb_done timing are unchanged.
- Reset mid-operation: any pending E/M/D write is dropped. No rf_we is issued after the reset edge, and no wb_done pulse is produced.
- wb_valid held high across busy cycles is not consumed. Its fields must stay stable until wb_ready is high.

Optional Feature:
- Macro: REGFILE_WB_DBG_PORT_EN.
- Defined: debug port is functional as described above.
- Undefined: dbg_ready is tied to 0, WR_D is unreachable, dbg_* inputs are ignored, and the ports remain present.

Decomposition:
- Shared package y86_pkg holds:
  - RNONE=4'hF, RSP=4'd4;
  - the state enum {IDLE, WR_E, WR_M, WR_D, NOP};
  - DW and AW constants.
- Natural sub-module: wb_port_mux. It is a registered 3:1 select of (addr, data) for the E, M and D sources plus the address-range check, driving rf_we, rf_waddr, rf_wdata and the addr_err set.
- The FSM stays in regfile_wb_sched.

Test Plan:
- OPq: wb dstE=3, valE=0x10, dstM=F -> cycle N+1: rf_we=1, waddr=3, wdata=0x10, wb_done=1. Cycle N+2: wb_ready=1.
- popq %rbx: dstE=4 valE=0x108, dstM=3 valM=0xAB -> N+1: write r4=0x108. N+2: write r3=0xAB with wb_done=1.
- popq %rsp: dstE=4 valE=0x108, dstM=4 valM=0x55 -> writes r4=0x108 then r4=0x55. The final r4 is 0x55.
- Debug vs wb: dbg_valid and wb_valid asserted together in IDLE -> wb wins with dbg_ready=0. Debug write r7=0x1234 issues once wb_done has passed and wb_valid is low. With the macro undefined, dbg_ready never rises.
- nop/jXX with dstE=dstM=F -> NOP cycle: rf_we=0, wb_done=1. Then wb_dstE=14 write succeeds; debug addr=14 succeeds. Debug addr=15 acts as RNONE (no write, no error); with NREG=12, dstE=13 gives rf_we=0 and addr_err=1 (sticky).
- Reset asserted during WR_E of a dual-write request -> next cycle: state IDLE, rf_we=0, no wb_done pulse, addr_err=0.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 write-back constants and scheduler state encoding
package y86_pkg;

    localparam int DW = 64;
    localparam int AW = 4;

    localparam logic [AW-1:0] RNONE = 4'hF;
    localparam logic [AW-1:0] RSP   = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        WR_E,
        WR_M,
        WR_D,
        NOP
    } state_e;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - write-back request, debug request and register-file port bundle
interface regfile_wb_sched_if;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [y86_pkg::AW-1:0]  wb_dstE;
    logic [y86_pkg::DW-1:0]  wb_valE;
    logic [y86_pkg::AW-1:0]  wb_dstM;
    logic [y86_pkg::DW-1:0]  wb_valM;
    logic                    dbg_valid;
    logic                    dbg_ready;
    logic [y86_pkg::AW-1:0]  dbg_addr;
    logic [y86_pkg::DW-1:0]  dbg_data;
    logic                    rf_we;
    logic [y86_pkg::AW-1:0]  rf_waddr;
    logic [y86_pkg::DW-1:0]  rf_wdata;
    logic                    wb_done;
    logic                    busy;
    logic                    addr_err;

    modport master (
        output wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
        output dbg_valid, dbg_addr, dbg_data,
        input  wb_ready, dbg_ready, rf_we, rf_waddr, rf_wdata, wb_done, busy, addr_err
    );

    modport slave (
        input  wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  dbg_valid, dbg_addr, dbg_data,
        output wb_ready, dbg_ready, rf_we, rf_waddr, rf_wdata, wb_done, busy, addr_err
    );

endinterface

// File: rtl/regfile_wb_sched_wb_port_mux.sv
// rtl/regfile_wb_sched_wb_port_mux.sv - registered E/M/D source select with address range check
module wb_port_mux
    import y86_pkg::*;
#(
    parameter int NREG = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  state_e        sel,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_data,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_data,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          addr_err
);

    localparam logic [AW-1:0] NREG_A = AW'(NREG);

    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          addr_err_q, addr_err_d;
    logic          active;

    // sel is the state being entered, so the port registers line up with it
    always_comb begin
        active     = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        unique case (sel)
            WR_E: begin
                active     = 1'b1;
                rf_waddr_d = e_addr;
                rf_wdata_d = e_data;
            end
            WR_M: begin
                active     = 1'b1;
                rf_waddr_d = m_addr;
                rf_wdata_d = m_data;
            end
            WR_D: begin
                active     = 1'b1;
                rf_waddr_d = d_addr;
                rf_wdata_d = d_data;
            end
            default: ;
        endcase
        // RNONE is a silent no-write; any other out-of-range address is an error
        rf_we_d    = active && (rf_waddr_d < NREG_A);
        addr_err_d = addr_err_q ||
                     (active && (rf_waddr_d != RNONE) && (rf_waddr_d >= NREG_A));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign addr_err = addr_err_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - serialises dual-result write-backs onto one register-file write port
// Optional debug/preload port enabled by defining REGFILE_WB_DBG_PORT_EN.
module regfile_wb_sched
    import y86_pkg::*;
#(
    parameter int NREG = 15
) (
    input  logic              clk,
    input  logic              reset,
    regfile_wb_sched_if.slave bus
);

`ifdef REGFILE_WB_DBG_PORT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] dst_e_q, dst_e_d;
    logic [DW-1:0] val_e_q, val_e_d;
    logic [AW-1:0] dst_m_q, dst_m_d;
    logic [DW-1:0] val_m_q, val_m_d;
    logic [AW-1:0] dbg_addr_q, dbg_addr_d;
    logic [DW-1:0] dbg_data_q, dbg_data_d;
    logic          wb_done_q, wb_done_d;
    logic          busy_q, busy_d;
    logic          dbg_accept;

    assign dbg_accept = DBG_EN && (state_q == IDLE) && !bus.wb_valid && bus.dbg_valid;

    always_comb begin
        state_d    = state_q;
        dst_e_d    = dst_e_q;
        val_e_d    = val_e_q;
        dst_m_d    = dst_m_q;
        val_m_d    = val_m_q;
        dbg_addr_d = dbg_addr_q;
        dbg_data_d = dbg_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wb_valid) begin
                    dst_e_d = bus.wb_dstE;
                    val_e_d = bus.wb_valE;
                    dst_m_d = bus.wb_dstM;
                    val_m_d = bus.wb_valM;
                    if (bus.wb_dstE != RNONE)      state_d = WR_E;
                    else if (bus.wb_dstM != RNONE) state_d = WR_M;
                    else                           state_d = NOP;
                end else if (dbg_accept) begin
                    dbg_addr_d = bus.dbg_addr;
                    dbg_data_d = bus.dbg_data;
                    state_d    = WR_D;
                end
            end
            WR_E:    state_d = (dst_m_q != RNONE) ? WR_M : IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered against the state being entered
        wb_done_d = (state_d == WR_M) || (state_d == NOP) ||
                    ((state_d == WR_E) && (dst_m_d == RNONE));
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dst_e_q    <= '0;
            val_e_q    <= '0;
            dst_m_q    <= '0;
            val_m_q    <= '0;
            dbg_addr_q <= '0;
            dbg_data_q <= '0;
            wb_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_e_q    <= dst_e_d;
            val_e_q    <= val_e_d;
            dst_m_q    <= dst_m_d;
            val_m_q    <= val_m_d;
            dbg_addr_q <= dbg_addr_d;
            dbg_data_q <= dbg_data_d;
            wb_done_q  <= wb_done_d;
            busy_q     <= busy_d;
        end
    end

    wb_port_mux #(.NREG(NREG)) u_wb_port_mux (
        .clk      (clk),
        .reset    (reset),
        .sel      (state_d),
        .e_addr   (dst_e_d),
        .e_data   (val_e_d),
        .m_addr   (dst_m_d),
        .m_data   (val_m_d),
        .d_addr   (dbg_addr_d),
        .d_data   (dbg_data_d),
        .rf_we    (bus.rf_we),
        .rf_waddr (bus.rf_waddr),
        .rf_wdata (bus.rf_wdata),
        .addr_err (bus.addr_err)
    );

    assign bus.wb_ready  = (state_q == IDLE);
    assign bus.dbg_ready = dbg_accept;
    assign bus.wb_done   = wb_done_q;
    assign bus.busy      = busy_q;

endmodule
